// File: rtl/matrix_mem_ctrl_if.sv
// rtl/matrix_mem_ctrl_if.sv - request/response bundle for the matrix memory
// Purpose: groups the request/ready handshake and read/status returns.
// Ports (master = requester, slave = memory):
//   req, we, addr, wdata, wmask, clear : requester -> memory
//   ready, rdata, rvalid, err, busy    : memory -> requester
interface matrix_mem_ctrl_if #(
    parameter int DATA_W = 256,
    parameter int LANE_W = 16,
    parameter int ADDR_W = 4
);
    logic                     req;
    logic                     we;
    logic [ADDR_W-1:0]        addr;
    logic [DATA_W-1:0]        wdata;
    logic [DATA_W/LANE_W-1:0] wmask;
    logic                     clear;
    logic                     ready;
    logic [DATA_W-1:0]        rdata;
    logic                     rvalid;
    logic                     err;
    logic                     busy;

    modport master (
        output req, we, addr, wdata, wmask, clear,
        input  ready, rdata, rvalid, err, busy
    );

    modport slave (
        input  req, we, addr, wdata, wmask, clear,
        output ready, rdata, rvalid, err, busy
    );
endinterface

// File: rtl/matrix_mem_ctrl.sv
// rtl/matrix_mem_ctrl.sv - single-port matrix memory with lane masks and clear sweep
// Purpose: DEPTH words of DATA_W bits, lane-masked writes, READ_LAT-deep read
// pipeline, zero-fill sweep on reset exit and on clear.
// Ports:
//   clk   : clock, rising edge
//   Reset : asynchronous, active-high
//   bus   : matrix_mem_ctrl_if slave (req/we/addr/wdata/wmask/clear in,
//           ready/rdata/rvalid/err/busy out)
module matrix_mem_ctrl #(
    parameter int DATA_W   = 256,
    parameter int LANE_W   = 16,
    parameter int DEPTH    = 8,
    parameter int ADDR_W   = 4,
    parameter int READ_LAT = 1
) (
    input logic              clk,
    input logic              Reset,
    matrix_mem_ctrl_if.slave bus
);
    localparam int LANES = DATA_W / LANE_W;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [0:0] ST_SWEEP = 1'b0;
    localparam logic [0:0] ST_IDLE  = 1'b1;

    localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

    logic [0:0]        state;
    logic [ADDR_W-1:0] sweepPtr;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              inRange;
    logic              acceptClear;
    logic              acceptOp;
    logic              acceptWrite;
    logic              acceptRead;
    logic [IDX_W-1:0]  opIdx;
    logic [IDX_W-1:0]  sweepIdx;
    logic [DATA_W-1:0] readWord;

    logic [READ_LAT-1:0] validPipe;
    logic [DATA_W-1:0]   dataPipe [READ_LAT];
    logic                errQ;

    // clear wins over req in the same cycle; the req is simply dropped
    always_comb begin
        inRange     = {1'b0, bus.addr} < DEPTH_X;
        acceptClear = (state == ST_IDLE) && bus.clear;
        acceptOp    = (state == ST_IDLE) && bus.req && !bus.clear;
        acceptWrite = acceptOp && bus.we && inRange;
        acceptRead  = acceptOp && !bus.we;
        opIdx       = bus.addr[IDX_W-1:0];
        sweepIdx    = sweepPtr[IDX_W-1:0];
        // out-of-range reads return zero rather than an aliased word
        readWord    = inRange ? mem[opIdx] : '0;
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state    <= ST_SWEEP;
            sweepPtr <= '0;
        end else if (state == ST_SWEEP) begin
            if (sweepPtr == LAST_PTR) begin
                state    <= ST_IDLE;
                sweepPtr <= '0;
            end else begin
                sweepPtr <= sweepPtr + 1'b1;
            end
        end else if (acceptClear) begin
            state <= ST_SWEEP;
        end
    end

    // Array has no reset: the sweep that follows reset zero-fills it.
    // Requests are only accepted in IDLE, so sweep and user writes never collide.
    always_ff @(posedge clk) begin
        if (state == ST_SWEEP) begin
            mem[sweepIdx] <= '0;
        end else if (acceptWrite) begin
            for (int i = 0; i < LANES; i++) begin
                if (bus.wmask[i]) begin
                    mem[opIdx][i*LANE_W +: LANE_W] <= bus.wdata[i*LANE_W +: LANE_W];
                end
            end
        end
    end

    // Data stages only load behind a valid, so the last stage holds the most
    // recent result while rvalid is low.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            validPipe <= '0;
            for (int i = 0; i < READ_LAT; i++) begin
                dataPipe[i] <= '0;
            end
            errQ <= 1'b0;
        end else begin
            validPipe[0] <= acceptRead;
            if (acceptRead) begin
                dataPipe[0] <= readWord;
            end
            for (int i = 1; i < READ_LAT; i++) begin
                validPipe[i] <= validPipe[i-1];
                if (validPipe[i-1]) begin
                    dataPipe[i] <= dataPipe[i-1];
                end
            end
            errQ <= acceptOp && !inRange;
        end
    end

    assign bus.ready  = (state == ST_IDLE);
    assign bus.busy   = (state == ST_SWEEP);
    assign bus.rvalid = validPipe[READ_LAT-1];
    assign bus.rdata  = dataPipe[READ_LAT-1];
    assign bus.err    = errQ;
endmodule

// File: tb/tb_matrix_mem_ctrl.sv
// tb/tb_matrix_mem_ctrl.sv - scoreboard bench for matrix_mem_ctrl at read latencies 1, 3 and 2
module tb_matrix_mem_ctrl;
    logic         clk;
    logic         Reset;
    logic         req;
    logic         we;
    logic [3:0]   addr;
    logic [255:0] wdata;
    logic [15:0]  wmask;
    logic         clear;

    matrix_mem_ctrl_if #(.DATA_W(256), .LANE_W(16), .ADDR_W(4)) busA ();
    matrix_mem_ctrl_if #(.DATA_W(256), .LANE_W(16), .ADDR_W(4)) busB ();
    matrix_mem_ctrl_if #(.DATA_W(256), .LANE_W(16), .ADDR_W(4)) busC ();

    matrix_mem_ctrl #(.DATA_W(256), .LANE_W(16), .DEPTH(8), .ADDR_W(4), .READ_LAT(1))
        dutA (.clk(clk), .Reset(Reset), .bus(busA));
    matrix_mem_ctrl #(.DATA_W(256), .LANE_W(16), .DEPTH(8), .ADDR_W(4), .READ_LAT(3))
        dutB (.clk(clk), .Reset(Reset), .bus(busB));
    matrix_mem_ctrl #(.DATA_W(256), .LANE_W(16), .DEPTH(8), .ADDR_W(4), .READ_LAT(2))
        dutC (.clk(clk), .Reset(Reset), .bus(busC));

    assign busA.req = req;   assign busB.req = req;   assign busC.req = req;
    assign busA.we = we;     assign busB.we = we;     assign busC.we = we;
    assign busA.addr = addr; assign busB.addr = addr; assign busC.addr = addr;
    assign busA.wdata = wdata; assign busB.wdata = wdata; assign busC.wdata = wdata;
    assign busA.wmask = wmask; assign busB.wmask = wmask; assign busC.wmask = wmask;
    assign busA.clear = clear; assign busB.clear = clear; assign busC.clear = clear;

    logic [2:0]   rvS, errS, readyS, busyS;
    logic [255:0] rdS [3];
    assign rvS    = {busC.rvalid, busB.rvalid, busA.rvalid};
    assign errS   = {busC.err, busB.err, busA.err};
    assign readyS = {busC.ready, busB.ready, busA.ready};
    assign busyS  = {busC.busy, busB.busy, busA.busy};
    assign rdS[0] = busA.rdata;
    assign rdS[1] = busB.rdata;
    assign rdS[2] = busC.rdata;

    typedef struct {
        logic [255:0] data;
        int           due;
    } exp_t;

    exp_t         sbq [3][$];
    logic [255:0] lastRd [3];
    logic [255:0] model [8];
    bit           errAt [4096];
    int           cyc;
    int           checks;
    int           errors;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int latOf(input int k);
        return (k == 0) ? 1 : (k == 1) ? 3 : 2;
    endfunction

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s observed %h required %h", tag, obs, want);
        end
    endtask

    // Per-cycle scoreboard: rvalid must match the queue head exactly at its due cycle.
    always @(negedge clk) begin
        exp_t e;
        for (int k = 0; k < 3; k++) begin
            if (rvS[k]) begin
                if (sbq[k].size() == 0) begin
                    check($sformatf("spuriousRvalid%0d", k), 256'(rvS[k]), 256'd0);
                end else begin
                    e = sbq[k].pop_front();
                    check($sformatf("rdata%0d", k), rdS[k], e.data);
                    check($sformatf("latency%0d", k), 256'(cyc), 256'(e.due));
                    lastRd[k] = e.data;
                end
            end else begin
                if (sbq[k].size() != 0 && sbq[k][0].due <= cyc) begin
                    check($sformatf("missingRvalid%0d", k), 256'(rvS[k]), 256'd1);
                    void'(sbq[k].pop_front());
                end
                check($sformatf("rdataHold%0d", k), rdS[k], lastRd[k]);
            end
            if (cyc < 4096) check($sformatf("err%0d", k), 256'(errS[k]), 256'(errAt[cyc]));
        end
    end

    task automatic checkState(input string tag, input logic r, input logic b);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("%s_ready%0d", tag, k), 256'(readyS[k]), 256'(r));
            check($sformatf("%s_busy%0d", tag, k), 256'(busyS[k]), 256'(b));
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            req = 1'b0; clear = 1'b0; we = 1'b0;
        end
    endtask

    // Called at the first negedge of a sweep: 8 busy cycles, then ready.
    task automatic sweepCheck(input string tag);
        for (int i = 0; i < 8; i++) begin
            checkState(tag, 1'b0, 1'b1);
            @(negedge clk);
            req = 1'b0; clear = 1'b0;
        end
        checkState({tag, "_done"}, 1'b1, 1'b0);
    endtask

    task automatic doWrite(input int a, input logic [255:0] d, input logic [15:0] m);
        @(negedge clk);
        checkState("preWrite", 1'b1, 1'b0);
        req = 1'b1; we = 1'b1; clear = 1'b0;
        addr = 4'(a); wdata = d; wmask = m;
        if (a < 8) begin
            for (int i = 0; i < 16; i++)
                if (m[i]) model[a][i*16 +: 16] = d[i*16 +: 16];
        end else begin
            errAt[cyc + 1] = 1'b1;
        end
    endtask

    task automatic doRead(input int a);
        exp_t e;
        @(negedge clk);
        checkState("preRead", 1'b1, 1'b0);
        req = 1'b1; we = 1'b0; clear = 1'b0;
        addr = 4'(a);
        e.data = (a < 8) ? model[a] : 256'd0;
        if (a >= 8) errAt[cyc + 1] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            e.due = cyc + latOf(k);
            sbq[k].push_back(e);
        end
    endtask

    task automatic doClearWithRead(input int a);
        @(negedge clk);
        clear = 1'b1; req = 1'b1; we = 1'b0; addr = 4'(a);
        for (int i = 0; i < 8; i++) model[i] = '0;
        @(negedge clk);
        clear = 1'b0; req = 1'b0;
        sweepCheck("clearSweep");
    endtask

    task automatic resetFlush();
        Reset = 1'b1;
        req = 1'b0; clear = 1'b0;
        for (int k = 0; k < 3; k++) begin
            sbq[k].delete();
            lastRd[k] = '0;
        end
        for (int i = 0; i < 8; i++) model[i] = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0; errors = 0; cyc = 0;
        Reset = 1'b0; req = 1'b0; we = 1'b0; addr = '0;
        wdata = '0; wmask = '0; clear = 1'b0;
        for (int k = 0; k < 3; k++) lastRd[k] = '0;
        for (int i = 0; i < 8; i++) model[i] = '0;
        #1;
        resetFlush();

        // reset state
        repeat (2) begin
            @(negedge clk);
            checkState("inReset", 1'b0, 1'b1);
            for (int k = 0; k < 3; k++) begin
                check($sformatf("resetRvalid%0d", k), 256'(rvS[k]), 256'd0);
                check($sformatf("resetRdata%0d", k), rdS[k], 256'd0);
            end
        end
        Reset = 1'b0;
        sweepCheck("resetSweep");

        // cleared array reads zero
        doRead(5);
        idle(5);

        // lane-masked merge and read-after-write on the next edge
        doWrite(3, {16{16'hABCD}}, 16'hFFFF);
        doWrite(3, {16{16'h1111}}, 16'h0001);
        doRead(3);
        idle(5);

        // fill word k with k, then back-to-back reads
        for (int k = 0; k < 8; k++) doWrite(k, 256'(k), 16'hFFFF);
        doWrite(4, {256{1'b1}}, 16'h0000);
        for (int k = 0; k < 8; k++) doRead(k);
        idle(6);

        // out-of-range boundaries: 8 and 9 read, 12 write; then words unchanged
        doRead(9);
        doRead(8);
        doRead(7);
        doWrite(12, {256{1'b1}}, 16'hFFFF);
        idle(2);
        for (int k = 0; k < 8; k++) doRead(k);
        idle(6);

        // clear with a read in flight and a same-cycle read that is dropped
        doWrite(2, {16{16'h5A5A}}, 16'hFFFF);
        doRead(2);
        doClearWithRead(2);
        doRead(2);
        idle(6);

        // asynchronous reset in the middle of a read
        doWrite(6, {16{16'hC3C3}}, 16'hFFFF);
        doRead(6);
        @(posedge clk);
        #2;
        resetFlush();
        repeat (3) begin
            @(negedge clk);
            checkState("midReset", 1'b0, 1'b1);
            for (int k = 0; k < 3; k++) begin
                check($sformatf("midResetRvalid%0d", k), 256'(rvS[k]), 256'd0);
                check($sformatf("midResetRdata%0d", k), rdS[k], 256'd0);
            end
        end
        Reset = 1'b0;
        sweepCheck("postResetSweep");
        doRead(6);
        idle(6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/matrix_mem_ctrl.md
Name: matrix_mem_ctrl

Overview:
Parametrised single-port matrix memory with a synchronous request/ready handshake, replacing the fixed 8x256 tristate-bus memory. It uses separate write-data and read-data buses, per-lane (16-bit element) write masks, a configurable read latency and a hardware clear sweep. It sits between the matrix datapath/controller and the register-file load/store path. One operation is accepted per clock.

Parameters:
DATA_W, 256, word width in bits (one 4x4 matrix of 16-bit elements)
LANE_W, 16, write-mask granularity; DATA_W must be a multiple of LANE_W
DEPTH, 8, number of words; need not be a power of two
ADDR_W, 4, address width; 2**ADDR_W >= DEPTH
READ_LAT, 1, cycles from read acceptance to rvalid; legal range 1..4

Ports:
clk  input  1  single clock; all state updates on rising edge
Reset  input  1  asynchronous, active-high reset
req  input  1  operation request
we  input  1  1 = write, 0 = read; sampled with req
addr  input  ADDR_W  word address
wdata  input  DATA_W  write data
wmask  input  DATA_W/LANE_W  per-lane write enable; bit i covers wdata[i*LANE_W +: LANE_W]
clear  input  1  request a zero-fill of the whole array
ready  output  1  block can accept req/clear this cycle
rdata  output  DATA_W  read data
rvalid  output  1  one-cycle pulse; rdata is valid
err  output  1  one-cycle pulse; out-of-range access accepted last cycle
busy  output  1  a clear sweep is in progress

Behaviour:
- Reset asserted, at any time including mid-operation, forces: FSM=SWEEP, sweep pointer=0, ready=0, busy=1, rvalid=0, err=0, rdata=0. In-flight reads are discarded.
- FSM states:
  - SWEEP: writes zero to word[ptr] each cycle; ptr increments from 0 to DEPTH-1. After the cycle that writes DEPTH-1, the FSM moves to IDLE. A sweep therefore takes exactly DEPTH cycles with ready=0.
  - IDLE: ready=1, busy=0.
  - Leaving reset enters SWEEP automatically. Array contents are never undefined after reset.
- Acceptance:
  - A request is accepted at a rising edge where ready=1.
  - clear has priority over req in the same cycle; the req is dropped, not queued.
  - clear with ready=1 moves the FSM to SWEEP. Requesters must not hold req during the sweep.
- Write (req&we):
  - At the accepting edge, lanes with wmask[i]=1 take the new data; lanes with 0 keep their old value.
  - wmask=0 is a legal no-op.
  - No rvalid is produced.
- Read (req&!we):
  - Data is the array content at the accepting edge, after any write from an earlier edge.
  - rdata/rvalid appear READ_LAT cycles after acceptance, through a READ_LAT-deep valid/data pipeline.
  - Back-to-back reads issue every cycle with full throughput; results return in order.
  - rdata holds its last value while rvalid=0.
- Read-after-write:
  - A write at edge N followed by a read of the same address at edge N+1 returns the new data.
  - A write and a read to the same word cannot occur in one cycle (single port).
- Clear with reads in flight: pipelined reads still complete with their pre-clear data; ready=0 during the sweep.
- Out of range (addr >= DEPTH):
  - A write is ignored.
  - A read returns rdata=0 with rvalid after READ_LAT cycles.
  - err pulses 1 the cycle after acceptance, for both reads and writes.
  - An in-range access gives err=0.

Test Plan:
- Reset release with default parameters -> ready=0, busy=1 for exactly 8 cycles, then ready=1; a read of address 5 returns 256'h0 with rvalid 1 cycle later.
- Write addr 3, wdata={16{16'hABCD}}, wmask=16'hFFFF; then write addr 3, wdata=all 16'h1111, wmask=16'h0001 -> read addr 3 returns lanes 15..1=16'hABCD and lane 0=16'h1111.
- READ_LAT=3: after filling word k with k, issue reads of addresses 0..7 on consecutive cycles -> rvalid high for 8 consecutive cycles starting 3 cycles after the first read, data 0..7 in order.
- Read addr 9 -> err=1 the cycle after acceptance, rdata=0 with rvalid; write to addr 12 -> err pulse and no array word changed.
- Assert clear and req (read addr 2) in the same cycle with word 2=16'h5A5A pattern -> read dropped, no rvalid; busy for 8 cycles; subsequent read of addr 2 returns 0.
- Assert Reset asynchronously mid-way through a READ_LAT=2 read -> rvalid stays 0, rdata=0; after release a full 8-cycle sweep occurs before ready=1.
